// File: rtl/elevator_pkg.sv
// Shared types and timing defaults for the elevator motion controller and the move-clock generator.
// Optional idle auto-return feature is enabled by defining ELEV_IDLE_RETURN_EN.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam int DEF_NUM_FLOORS      = 3;
  localparam int DEF_TICKS_PER_FLOOR = 4;
  localparam int DEF_DOOR_CYCLES     = 50;
  localparam int DEF_IDLE_CYCLES     = 200;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FLOOR_W = floor_w(DEF_NUM_FLOORS);

endpackage

// File: rtl/elevator_door_timer.sv
// Load/reload/done counter: counts 0..LIMIT-1 while not loaded and holds at LIMIT-1 with done high.
// Used for the door dwell and for the idle auto-return timer.
module elevator_door_timer
  import elevator_pkg::*;
#(
  parameter int LIMIT = DEF_DOOR_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = floor_w(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Elevator car controller: tracks floor from move_clk ticks, latches calls, runs travel and door sequencing.
// Define ELEV_IDLE_RETURN_EN to send a parked car back to floor 0 after IDLE_CYCLES without calls.
module elevator_motion_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
  parameter int TICKS_PER_FLOOR = DEF_TICKS_PER_FLOOR,
  parameter int DOOR_CYCLES     = DEF_DOOR_CYCLES,
  parameter int IDLE_CYCLES     = DEF_IDLE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           move_clk,
  input  logic [NUM_FLOORS-1:0]          call_req,
  input  logic                           sos_mode,
  input  logic                           weight_limit_exceeded,
  output logic [NUM_FLOORS-1:0]          call_led,
  output logic                           move_handler,
  output logic                           dir_up,
  output logic [floor_w(NUM_FLOORS)-1:0] cur_floor,
  output logic                           door_open,
  output logic                           arrived
);

  localparam int FW = floor_w(NUM_FLOORS);
  localparam int TW = floor_w(TICKS_PER_FLOOR);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_FLOOR - 1);

  state_t                  state, state_nxt;
  logic [FW-1:0]           floor_nxt, floor_step;
  logic                    dir_nxt;
  logic [TW-1:0]           tick_cnt, tick_nxt;
  logic [NUM_FLOORS-1:0]   led_nxt, led_set, led_clr, pending, idle_ret, cur_mask;
  logic                    arrived_nxt;
  logic                    move_clk_q, tick;
  logic                    calls_above, calls_below;
  logic                    door_reload, door_load, door_done;

  assign pending  = call_led | call_req;
  assign cur_mask = NUM_FLOORS'(1) << cur_floor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_clk_q <= 1'b0;
      tick       <= 1'b0;
    end else begin
      move_clk_q <= move_clk;
      tick       <= move_clk & ~move_clk_q;
    end
  end

  always_comb begin
    calls_above = 1'b0;
    calls_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(cur_floor)) calls_above = calls_above | call_led[i];
      if (i < int'(cur_floor)) calls_below = calls_below | call_led[i];
    end
  end

  // Saturates at the shaft ends so the floor index can never leave range.
  always_comb begin
    floor_step = cur_floor;
    if (dir_up && cur_floor != TOP_FLOOR) begin
      floor_step = cur_floor + 1'b1;
    end else if (!dir_up && cur_floor != '0) begin
      floor_step = cur_floor - 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    floor_nxt   = cur_floor;
    dir_nxt     = dir_up;
    tick_nxt    = tick_cnt;
    arrived_nxt = 1'b0;
    led_set     = call_req;
    led_clr     = '0;
    door_reload = 1'b0;
    case (state)
      ST_IDLE: begin
        if (call_led[cur_floor]) begin
          led_clr     = cur_mask;
          arrived_nxt = 1'b1;
          state_nxt   = ST_DOOR;
        end else if ((|call_led) && !sos_mode && !weight_limit_exceeded) begin
          dir_nxt   = dir_up ? calls_above : !calls_below;
          state_nxt = ST_MOVE;
        end
      end
      ST_MOVE: begin
        // Emergency hold freezes position but keeps the motor request asserted.
        if (tick && !sos_mode) begin
          if (tick_cnt == LAST_TICK) begin
            tick_nxt  = '0;
            floor_nxt = floor_step;
            if (pending[floor_step]) begin
              led_clr     = NUM_FLOORS'(1) << floor_step;
              arrived_nxt = 1'b1;
              state_nxt   = ST_DOOR;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      ST_DOOR: begin
        door_reload = call_req[cur_floor] | weight_limit_exceeded;
        led_set     = call_req & ~cur_mask;
        if (!door_reload && door_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (floor_nxt == '0) begin
      dir_nxt = 1'b1;
    end else if (floor_nxt == TOP_FLOOR) begin
      dir_nxt = 1'b0;
    end
    led_nxt = (call_led | led_set | idle_ret) & ~led_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      tick_cnt  <= '0;
      call_led  <= '0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_floor <= floor_nxt;
      dir_up    <= dir_nxt;
      tick_cnt  <= tick_nxt;
      call_led  <= led_nxt;
      arrived   <= arrived_nxt;
    end
  end

  assign door_load = (state != ST_DOOR) || door_reload;

  elevator_door_timer #(.LIMIT(DOOR_CYCLES)) u_door_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (door_load),
    .en    (1'b1),
    .done  (door_done)
  );

`ifdef ELEV_IDLE_RETURN_EN
  logic idle_load, idle_done;

  // Any pending call, leaving IDLE, or already being on the ground floor restarts the wait.
  assign idle_load = (state != ST_IDLE) || (|pending) || (cur_floor == '0);

  elevator_door_timer #(.LIMIT(IDLE_CYCLES)) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (idle_load),
    .en    (1'b1),
    .done  (idle_done)
  );

  assign idle_ret = NUM_FLOORS'(idle_done && !idle_load);
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = (IDLE_CYCLES > 0);
  assign idle_ret        = '0;
`endif

  assign move_handler = (state == ST_MOVE);
  assign door_open    = (state == ST_DOOR);

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl: arrival scoreboard plus immediate-assertion checks.
// Build with ELEV_IDLE_RETURN_EN to also exercise the idle auto-return.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_clk = 1'b0;
  logic [2:0] call_req = '0;
  logic       sos_mode = 1'b0;
  logic       weight_limit_exceeded = 1'b0;
  logic [2:0] call_led;
  logic       move_handler, dir_up, door_open, arrived;
  logic [1:0] cur_floor;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int door_run = 0;
  int last_door_len = 0;

  elevator_motion_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .move_clk              (move_clk),
    .call_req              (call_req),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .call_led              (call_led),
    .move_handler          (move_handler),
    .dir_up                (dir_up),
    .cur_floor             (cur_floor),
    .door_open             (door_open),
    .arrived               (arrived)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every arrival pulse must match the next expected floor.
  always @(negedge clk) begin
    if (rst_n && arrived) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_arrival observed_floor=%0d expected=none", cur_floor);
      end else begin
        automatic int ef = exp_q.pop_front();
        assert (32'(cur_floor) === ef) else begin
          failures++;
          $error("FAIL arrival_floor observed=%0d expected=%0d", cur_floor, ef);
        end
      end
    end
    if (door_open) begin
      door_run++;
    end else if (door_run != 0) begin
      last_door_len = door_run;
      door_run = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      move_clk = 1'b1;
      step(2);
      move_clk = 1'b0;
      step(2);
    end
  endtask

  task automatic call(input logic [2:0] p);
    call_req = p;
    step(1);
    call_req = '0;
  endtask

  task automatic wait_door_closed(input string tag);
    int n = 0;
    while (door_open && n < 500) begin
      step(1);
      n++;
    end
    chk(tag, 32'(door_open), 0);
  endtask

  initial begin
    int n;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_call_led", 32'(call_led), 0);
    chk("rst_move", 32'(move_handler), 0);
    chk("rst_dir_up", 32'(dir_up), 1);
    chk("rst_floor", 32'(cur_floor), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_arrived", 32'(arrived), 0);

    // Up to floor 2 from ground.
    exp_q.push_back(2);
    call(3'b100);
    chk("t1_led_latched", 32'(call_led), 4);
    chk("t1_move_not_yet", 32'(move_handler), 0);
    step(1);
    chk("t1_move_2clk", 32'(move_handler), 1);
    chk("t1_dir_up", 32'(dir_up), 1);
    ticks(4);
    chk("t1_floor1", 32'(cur_floor), 1);
    chk("t1_pass_floor1", 32'(move_handler), 1);
    ticks(4);
    chk("t1_floor2", 32'(cur_floor), 2);
    chk("t1_door_open", 32'(door_open), 1);
    chk("t1_led_cleared", 32'(call_led), 0);
    wait_door_closed("t1_door_closes");
    step(1);
    chk("t1_door_len", 32'(last_door_len), 50);

    // Down to ground without stopping at floor 1.
    exp_q.push_back(0);
    call(3'b001);
    step(1);
    chk("t2_move", 32'(move_handler), 1);
    chk("t2_dir_down", 32'(dir_up), 0);
    ticks(4);
    chk("t2_floor1", 32'(cur_floor), 1);
    chk("t2_no_stop", 32'(door_open), 0);
    ticks(4);
    chk("t2_floor0", 32'(cur_floor), 0);
    chk("t2_door_open", 32'(door_open), 1);
    wait_door_closed("t2_door_closes");
    step(1);
    chk("t2_door_len", 32'(last_door_len), 50);

    // Emergency hold mid-floor keeps the partial tick count.
    exp_q.push_back(2);
    call(3'b100);
    step(1);
    ticks(2);
    sos_mode = 1'b1;
    ticks(20);
    chk("t3_sos_floor", 32'(cur_floor), 0);
    chk("t3_sos_move", 32'(move_handler), 1);
    sos_mode = 1'b0;
    ticks(2);
    chk("t3_resume_floor1", 32'(cur_floor), 1);
    ticks(4);
    chk("t3_floor2", 32'(cur_floor), 2);
    chk("t3_door_open", 32'(door_open), 1);
    wait_door_closed("t3_door_closes");
    step(1);

    // Overload holds the door and blocks departure.
    exp_q.push_back(2);
    call(3'b100);
    weight_limit_exceeded = 1'b1;
    step(100);
    chk("t4_door_held", 32'(door_open), 1);
    weight_limit_exceeded = 1'b0;
    n = 0;
    while (door_open && n < 500) begin
      step(1);
      n++;
    end
    chk("t4_close_after_release", 32'(n), 50);
    weight_limit_exceeded = 1'b1;
    call(3'b001);
    step(10);
    chk("t4_no_departure", 32'(move_handler), 0);
    chk("t4_led_pending", 32'(call_led), 1);
    weight_limit_exceeded = 1'b0;
    exp_q.push_back(0);
    step(1);
    chk("t4_departs", 32'(move_handler), 1);
    ticks(8);
    chk("t4_floor0", 32'(cur_floor), 0);
    wait_door_closed("t4_door_closes");
    step(1);

    // Intermediate stop picked up while travelling.
    call(3'b100);
    step(1);
    call(3'b010);
    exp_q.push_back(1);
    exp_q.push_back(2);
    ticks(4);
    chk("t5_stop_floor1", 32'(cur_floor), 1);
    chk("t5_door_open", 32'(door_open), 1);
    chk("t5_led_remaining", 32'(call_led), 4);
    wait_door_closed("t5_door1_closes");
    step(1);
    chk("t5_continue", 32'(move_handler), 1);
    chk("t5_continue_dir", 32'(dir_up), 1);
    ticks(4);
    chk("t5_floor2", 32'(cur_floor), 2);
    chk("t5_led_clear", 32'(call_led), 0);
    wait_door_closed("t5_door2_closes");
    step(1);

    // Asynchronous reset during travel.
    call(3'b001);
    step(1);
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_move", 32'(move_handler), 0);
    chk("t6_rst_floor", 32'(cur_floor), 0);
    chk("t6_rst_led", 32'(call_led), 0);
    chk("t6_rst_dir", 32'(dir_up), 1);
    chk("t6_rst_door", 32'(door_open), 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t6_stays_parked", 32'(move_handler), 0);

`ifdef ELEV_IDLE_RETURN_EN
    exp_q.push_back(2);
    call(3'b100);
    step(1);
    ticks(8);
    wait_door_closed("t7_door_closes");
    n = 0;
    while (!move_handler && n < 400) begin
      step(1);
      n++;
    end
    chk("t7_idle_return_delay", 32'(n), 201);
    chk("t7_return_dir", 32'(dir_up), 0);
    exp_q.push_back(0);
    ticks(8);
    chk("t7_floor0", 32'(cur_floor), 0);
    wait_door_closed("t7_door0_closes");
`endif

    step(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
